// File: rtl/ibex_pmp_csr.sv
// ibex_pmp_csr: PMP configuration and address CSR storage for the ibex_pmp checker.
// This block decodes pmpcfg0-3 (0x3A0-0x3A3) and pmpaddr0-15 (0x3B0-0x3BF).
// It applies WARL legalisation and lock rules, and masks pmpaddr read-back to the granule.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   csr_access_i, csr_we_i    CSR access valid / write enable (write data already op-resolved)
//   csr_addr_i, csr_wdata_i   CSR address / write data
//   csr_rdata_o, csr_hit_o    combinational read data / address falls in a PMP range
//   csr_pmp_cfg_o             per entry {lock, mode[1:0], exec, write, read}
//   csr_pmp_addr_o            per entry {pmpaddr, 2'b00}
//   pmp_update_o              one-cycle pulse after any stored bit changed
module ibex_pmp_csr #(
    parameter int PMPGranularity = 0,
    parameter int PMPNumRegions  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  csr_access_i,
    input  logic                                  csr_we_i,
    input  logic [11:0]                           csr_addr_i,
    input  logic [31:0]                           csr_wdata_i,
    output logic [31:0]                           csr_rdata_o,
    output logic                                  csr_hit_o,
    output logic [PMPNumRegions-1:0][5:0]         csr_pmp_cfg_o,
    output logic [PMPNumRegions-1:0][33:0]        csr_pmp_addr_o,
    output logic                                  pmp_update_o
);
    localparam int N = PMPNumRegions;
    localparam logic [1:0] ModeOff   = 2'b00;
    localparam logic [1:0] ModeTor   = 2'b01;
    localparam logic [1:0] ModeNa4   = 2'b10;
    localparam logic [1:0] ModeNapot = 2'b11;

    logic                 cfg_sel, addr_sel, wr_en;
    logic [N-1:0][5:0]    cfg_q, cfg_d;
    logic [N-1:0][31:0]   addr_q, addr_d;
    logic [N-1:0][31:0]   rd_vec;
    logic                 upd_q;

    assign cfg_sel   = (csr_addr_i[11:2] == 10'h0E8);
    assign addr_sel  = (csr_addr_i[11:4] == 8'h3B);
    assign csr_hit_o = cfg_sel | addr_sel;
    assign wr_en     = csr_access_i & csr_we_i & csr_hit_o;

    for (genvar i = 0; i < N; i++) begin : g_entry
        localparam int unsigned CR  = i / 4;   // pmpcfg register holding this entry
        localparam int unsigned CB  = i % 4;   // byte lane within that register
        localparam int unsigned IDX = i;

        logic [7:0]  wbyte;
        logic [5:0]  cfg_new;
        logic        cfg_wr, addr_wr, addr_lock, next_tor_lock;
        logic [31:0] addr_rd;

        assign wbyte = csr_wdata_i[8*CB +: 8];

        // NA4 cannot be represented once the granule exceeds 4 bytes, so it degrades to OFF.
        always_comb begin
            cfg_new = {wbyte[7], wbyte[4:3], wbyte[2:0]};
            if (PMPGranularity >= 1 && wbyte[4:3] == ModeNa4) cfg_new[4:3] = ModeOff;
        end

        // Locked entries and the reserved R=0/W=1 encoding leave the whole byte untouched.
        assign cfg_wr = wr_en & cfg_sel & (csr_addr_i[1:0] == CR[1:0]) &
                        ~cfg_q[i][5] & ~(~wbyte[0] & wbyte[1]);

        // A locked TOR entry above also freezes this entry's address (it is the TOR base).
        if (i < N - 1) begin : g_next
            assign next_tor_lock = cfg_q[i+1][5] & (cfg_q[i+1][4:3] == ModeTor);
        end else begin : g_last
            assign next_tor_lock = 1'b0;
        end

        assign addr_lock = cfg_q[i][5] | next_tor_lock;
        assign addr_wr   = wr_en & addr_sel & (csr_addr_i[3:0] == IDX[3:0]) & ~addr_lock;

        assign cfg_d[i]  = cfg_wr  ? cfg_new     : cfg_q[i];
        assign addr_d[i] = addr_wr ? csr_wdata_i : addr_q[i];

        // Read-back masking only; the stored address stays raw.
        always_comb begin
            addr_rd = addr_q[i];
            if (PMPGranularity >= 1) begin
                for (int b = 0; b < 32; b++) begin
                    if (cfg_q[i][4:3] == ModeNapot) begin
                        if (b < PMPGranularity - 1) addr_rd[b] = 1'b1;
                    end else if (b < PMPGranularity) begin
                        addr_rd[b] = 1'b0;
                    end
                end
            end
        end

        always_comb begin
            rd_vec[i] = 32'b0;
            if (cfg_sel && csr_addr_i[1:0] == CR[1:0])
                rd_vec[i][8*CB +: 8] = {cfg_q[i][5], 2'b00, cfg_q[i][4:0]};
            else if (addr_sel && csr_addr_i[3:0] == IDX[3:0])
                rd_vec[i] = addr_rd;
        end

        assign csr_pmp_cfg_o[i]  = cfg_q[i];
        assign csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
    end

    // Entries not selected contribute zero, so OR-ing gives the mux; unimplemented slots read 0.
    always_comb begin
        csr_rdata_o = 32'b0;
        for (int i = 0; i < N; i++) csr_rdata_o = csr_rdata_o | rd_vec[i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q  <= '0;
            addr_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            addr_q <= addr_d;
            upd_q  <= wr_en & ((cfg_d != cfg_q) | (addr_d != addr_q));
        end
    end

    assign pmp_update_o = upd_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// tb_ibex_pmp_csr: directed checks of ibex_pmp_csr with a G=0 instance and a G=2 instance.
// Both instances share the same stimulus.
module tb_ibex_pmp_csr;
    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               csr_access_i = 1'b0;
    logic               csr_we_i = 1'b0;
    logic [11:0]        csr_addr_i = '0;
    logic [31:0]        csr_wdata_i = '0;
    logic [31:0]        rdata, rdata_g2;
    logic               hit, hit_g2;
    logic [3:0][5:0]    cfg, cfg_g2;
    logic [3:0][33:0]   paddr, paddr_g2;
    logic               upd, upd_g2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .csr_access_i(csr_access_i), .csr_we_i(csr_we_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(rdata),
        .csr_hit_o(hit), .csr_pmp_cfg_o(cfg), .csr_pmp_addr_o(paddr), .pmp_update_o(upd));

    ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(4)) u_dut_g2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .csr_access_i(csr_access_i), .csr_we_i(csr_we_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(rdata_g2),
        .csr_hit_o(hit_g2), .csr_pmp_cfg_o(cfg_g2), .csr_pmp_addr_o(paddr_g2),
        .pmp_update_o(upd_g2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write, then check the update pulse one delta after the committing edge.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_upd,
                      input string tag);
        @(negedge clk_i);
        csr_access_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
        @(posedge clk_i); #1;
        csr_access_i = 1'b0; csr_we_i = 1'b0;
        chk(tag, {63'b0, upd}, {63'b0, exp_upd});
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk_i);
        csr_access_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = a;
        #1;
        chk(tag, {32'b0, rdata}, {32'b0, exp});
        csr_access_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_cfg", {40'b0, cfg}, 64'h0);
        chk("rst_addr_zero", {63'b0, |paddr}, 64'h0);
        chk("rst_upd", {63'b0, upd}, 64'h0);
        @(negedge clk_i); rst_ni = 1'b1;
        rd(12'h3A0, 32'h0, "rst_rd_3a0");
        rd(12'h3B0, 32'h0, "rst_rd_3b0");

        // Basic cfg write: entry0 TOR RW, entry1 NAPOT RWX
        wr(12'h3A0, 32'h0000_1F0B, 1'b1, "cfg_wr_upd");
        chk("cfg0", {58'b0, cfg[0]}, 64'h0B);
        chk("cfg1", {58'b0, cfg[1]}, 64'h1F);
        rd(12'h3A0, 32'h0000_1F0B, "cfg_rd");
        @(posedge clk_i); #1;
        chk("upd_drop", {63'b0, upd}, 64'h0);

        // Identical data and reserved R=0/W=1 encoding: no change, no pulse
        wr(12'h3A0, 32'h0000_1F0B, 1'b0, "same_wr_upd");
        wr(12'h3A0, 32'h0000_1F02, 1'b0, "rsvd_wr_upd");
        rd(12'h3A0, 32'h0000_1F0B, "rsvd_rd");

        // Address write; G=2 masking with TOR, NAPOT, and NA4 demoted to OFF
        wr(12'h3B0, 32'h0000_0100, 1'b1, "addr0_upd");
        chk("addr0_out", {30'b0, paddr[0]}, 64'h400);
        rd(12'h3B0, 32'h0000_0100, "addr0_rd");
        chk("g2_tor_rd", {32'b0, rdata_g2}, 64'h100);
        wr(12'h3A0, 32'h0000_1F1B, 1'b1, "napot_upd");
        rd(12'h3B0, 32'h0000_0100, "g0_napot_rd");
        chk("g2_napot_rd", {32'b0, rdata_g2}, 64'h101);
        wr(12'h3A0, 32'h0000_1F13, 1'b1, "na4_upd");
        rd(12'h3A0, 32'h0000_1F13, "g0_na4_rd");
        chk("g2_na4_off_rd", {32'b0, rdata_g2}, 64'h1F03);
        chk("g2_stored_raw", {30'b0, paddr_g2[0]}, 64'h400);

        // Lock entry1 as TOR
        wr(12'h3A0, 32'h0000_8813, 1'b1, "lock_upd");
        chk("lock_cfg1", {58'b0, cfg[1]}, 64'h28);
        rd(12'h3A0, 32'h0000_8813, "lock_rd");
        wr(12'h3B0, 32'h0000_1234, 1'b0, "tor_base_upd");
        rd(12'h3B0, 32'h0000_0100, "tor_base_rd");
        wr(12'h3B1, 32'h0000_ABCD, 1'b0, "locked_addr_upd");
        rd(12'h3B1, 32'h0, "locked_addr_rd");
        wr(12'h3A0, 32'h0000_0013, 1'b0, "unlock_upd");
        rd(12'h3A0, 32'h0000_8813, "sticky_rd");

        // Unimplemented entries and out-of-range address
        wr(12'h3A1, 32'hFFFF_FFFF, 1'b0, "unimp_cfg_upd");
        rd(12'h3A1, 32'h0, "unimp_cfg_rd");
        chk("unimp_cfg_hit", {63'b0, hit}, 64'h1);
        wr(12'h3B5, 32'h0000_0055, 1'b0, "unimp_addr_upd");
        rd(12'h3B5, 32'h0, "unimp_addr_rd");
        chk("unimp_addr_hit", {63'b0, hit}, 64'h1);
        rd(12'h3C0, 32'h0, "miss_rd");
        chk("miss_hit", {63'b0, hit}, 64'h0);

        // Last entry has no next-entry TOR rule; back-to-back writes pulse twice
        wr(12'h3B3, 32'h0000_DEAD, 1'b1, "addr3_upd");
        chk("addr3_out", {30'b0, paddr[3]}, 64'h37AB4);
        wr(12'h3B2, 32'h0000_0001, 1'b1, "b2b_upd0");
        wr(12'h3B2, 32'h0000_0002, 1'b1, "b2b_upd1");
        rd(12'h3B2, 32'h0000_0002, "b2b_rd");

        // Async reset clears the lock as well
        #2; rst_ni = 1'b0; #1;
        chk("rst2_cfg", {40'b0, cfg}, 64'h0);
        chk("rst2_addr_zero", {63'b0, |paddr}, 64'h0);
        chk("rst2_upd", {63'b0, upd}, 64'h0);
        @(negedge clk_i); rst_ni = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
